// File: rtl/imm_gen_pkg.sv
// Shared immediate-generation types, field widths and the sign-extension helper.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_C    = 3'd6
  } imm_type_t;

  localparam int unsigned IMM_I_WIDTH = 12;
  localparam int unsigned IMM_S_WIDTH = 12;
  localparam int unsigned IMM_B_WIDTH = 13;
  localparam int unsigned IMM_U_WIDTH = 20;
  localparam int unsigned IMM_J_WIDTH = 21;
  localparam int unsigned IMM_C_WIDTH = 5;

  // Sign-extend the low `width` bits of value to 32 bits; width must be 1..32.
  function automatic logic [31:0] imm_sext(input logic [31:0] value, input int unsigned width);
    logic [31:0] shifted;
    shifted = value << (32 - width);
    return $signed(shifted) >>> (32 - width);
  endfunction

endpackage

// File: rtl/decode_imm_stage_if.sv
// Decode-side and execute-side handshake bundle of the immediate stage.
interface decode_imm_stage_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PC_WIDTH = 32
) ();
  import imm_gen_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  imm_type_t           in_imm_type;

  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_instr;
  logic [PC_WIDTH-1:0] out_pc;
  logic [XLEN-1:0]     out_imm;
  imm_type_t           out_imm_type;

  // The stage itself.
  modport master (
    input  in_valid, in_instr, in_pc, in_imm_type, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_type
  );

  // Decode producer plus execute consumer around the stage.
  modport slave (
    output in_valid, in_instr, in_pc, in_imm_type, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_type
  );

endinterface

// File: rtl/imm_expand.sv
// Pure combinational immediate expansion from a raw instruction and its immediate type.
module imm_expand
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  imm_type_t       i_imm_type,
  output logic [XLEN-1:0] o_imm
);

  // The opcode field never contributes to an immediate.
  logic w_unused_opcode;
  assign w_unused_opcode = ^i_instr[6:0];

  always_comb begin
    o_imm = '0;
    case (i_imm_type)
      IMM_I: o_imm = imm_sext({20'b0, i_instr[31:20]}, IMM_I_WIDTH);
      IMM_S: o_imm = imm_sext({20'b0, i_instr[31:25], i_instr[11:7]}, IMM_S_WIDTH);
      IMM_B: o_imm = imm_sext({19'b0, i_instr[31], i_instr[7], i_instr[30:25],
                               i_instr[11:8], 1'b0}, IMM_B_WIDTH);
      IMM_U: o_imm = {i_instr[31:12], 12'b0};
      IMM_J: o_imm = imm_sext({11'b0, i_instr[31], i_instr[19:12], i_instr[20],
                               i_instr[30:21], 1'b0}, IMM_J_WIDTH);
      IMM_C: o_imm = {{(32 - IMM_C_WIDTH){1'b0}}, i_instr[19:15]};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_imm_stage.sv
// Decode-to-execute stage: expands the immediate at accept and holds beats in a
// 2-entry skid buffer so in_ready is a pure register output.
module decode_imm_stage
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PC_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  input logic                flush,
  decode_imm_stage_if.master bus
);

  if (XLEN != 32) begin : g_xlen_check
    $error("decode_imm_stage: only XLEN = 32 is supported");
  end

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
    imm_type_t           imm_type;
    logic [XLEN-1:0]     imm;
  } beat_t;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam beat_t BEAT_RST = '{instr: '0, pc: '0, imm_type: IMM_NONE, imm: '0};

  logic            r_m_valid;
  logic            r_s_valid;
  beat_t           r_m;
  beat_t           r_s;
  logic [XLEN-1:0] w_imm;
  beat_t           w_in;
  logic [1:0]      w_state;
  logic            w_accept;
  logic            w_xfer;

  imm_expand #(
    .XLEN(XLEN)
  ) u_imm_expand (
    .i_instr   (bus.in_instr),
    .i_imm_type(bus.in_imm_type),
    .o_imm     (w_imm)
  );

  always_comb begin
    w_in     = '{instr: bus.in_instr, pc: bus.in_pc, imm_type: bus.in_imm_type, imm: w_imm};
    w_state  = {r_s_valid, r_m_valid};
    w_accept = bus.in_valid & bus.in_ready;
    w_xfer   = r_m_valid & bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m       <= BEAT_RST;
      r_s       <= BEAT_RST;
    end else if (flush) begin
      // Only valid bits are dropped; stale data is harmless once invalid.
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else begin
      case (w_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m       <= w_in;
          end
        end
        ST_ONE: begin
          if (w_accept && w_xfer) begin
            r_m <= w_in;
          end else if (w_accept) begin
            r_s_valid <= 1'b1;
            r_s       <= w_in;
          end else if (w_xfer) begin
            r_m_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_xfer) begin
            r_m       <= r_s;
            r_s_valid <= 1'b0;
          end
        end
        default: begin
          r_m_valid <= 1'b0;
          r_s_valid <= 1'b0;
        end
      endcase
    end
  end

  // rst gating keeps in_ready low during reset; out_ready never reaches it.
  assign bus.in_ready     = ~r_s_valid & ~rst;
  assign bus.out_valid    = r_m_valid;
  assign bus.out_instr    = r_m.instr;
  assign bus.out_pc       = r_m.pc;
  assign bus.out_imm      = r_m.imm;
  assign bus.out_imm_type = r_m.imm_type;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Scoreboard bench for decode_imm_stage: directed vectors with hand-computed immediates.
module tb_decode_imm_stage;
  import imm_gen_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  decode_imm_stage_if #(.XLEN(32), .PC_WIDTH(32)) bus ();

  decode_imm_stage #(
    .XLEN    (32),
    .PC_WIDTH(32)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    imm_type_t   t;
    logic [31:0] imm;
  } exp_t;

  localparam int NV = 15;

  logic [31:0] v_instr [NV] = '{
    32'hFFF00093, 32'hFE112E23, 32'h123450B7, 32'h3402D073, 32'hFFF00093,
    32'h00000463, 32'hFE000EE3, 32'h010000EF, 32'hFFDFF0EF, 32'h80000013,
    32'h7FF00013, 32'h00112423, 32'hFFFF8073, 32'hFFFFF037, 32'hFFFFFFFF
  };
  imm_type_t v_type [NV] = '{
    IMM_I, IMM_S, IMM_U, IMM_C, IMM_NONE,
    IMM_B, IMM_B, IMM_J, IMM_J, IMM_I,
    IMM_I, IMM_S, IMM_C, IMM_U, imm_type_t'(3'd7)
  };
  logic [31:0] v_imm [NV] = '{
    32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h00000005, 32'h00000000,
    32'h00000008, 32'hFFFFFFFC, 32'h00000010, 32'hFFFFFFFC, 32'hFFFFF800,
    32'h000007FF, 32'h00000008, 32'h0000001F, 32'hFFFFF000, 32'h00000000
  };

  exp_t sb_q[$];
  exp_t cur_exp;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int idx, input logic [31:0] pc);
    bus.in_valid    = 1'b1;
    bus.in_instr    = v_instr[idx];
    bus.in_pc       = pc;
    bus.in_imm_type = v_type[idx];
    cur_exp         = '{instr: v_instr[idx], pc: pc, t: v_type[idx], imm: v_imm[idx]};
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: %0d beats pending after %0d cycles, expected 0", name, sb_q.size(), n);
    end
  endtask

  // Monitor: pops on transfer, pushes on accept, and checks stall stability.
  logic stall_prev = 1'b0;
  exp_t prev_out;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", 32'(bus.out_valid), 32'd1);
          check("stall_instr", bus.out_instr, prev_out.instr);
          check("stall_pc", bus.out_pc, prev_out.pc);
          check("stall_imm", bus.out_imm, prev_out.imm);
          check("stall_type", 32'(bus.out_imm_type), 32'(prev_out.t));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_beat: got pc %08h, expected no beat", bus.out_pc);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("beat_instr", bus.out_instr, e.instr);
            check("beat_pc", bus.out_pc, e.pc);
            check("beat_imm", bus.out_imm, e.imm);
            check("beat_type", 32'(bus.out_imm_type), 32'(e.t));
          end
        end
        if (flush) sb_q.delete();
        else if (bus.in_valid && bus.in_ready) sb_q.push_back(cur_exp);
        stall_prev = bus.out_valid & ~bus.out_ready & ~flush;
        prev_out   = '{instr: bus.out_instr, pc: bus.out_pc, t: bus.out_imm_type,
                       imm: bus.out_imm};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int sent;
    int guard;
    bus.in_valid    = 1'b0;
    bus.in_instr    = '0;
    bus.in_pc       = '0;
    bus.in_imm_type = IMM_NONE;
    bus.out_ready   = 1'b0;
    cur_exp         = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_imm", bus.out_imm, 32'd0);
    check("rst_out_type", 32'(bus.out_imm_type), 32'(IMM_NONE));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ADDI latency: nothing on the accept cycle, result the cycle after
    bus.out_ready = 1'b1;
    tick();
    put(0, 32'h0000_1000);
    @(negedge clk);
    check("lat_valid_n", 32'(bus.out_valid), 32'd0);
    tick();
    idle();
    @(negedge clk);
    check("lat_valid_n1", 32'(bus.out_valid), 32'd1);
    check("addi_imm", bus.out_imm, 32'hFFFFFFFF);

    // All directed vectors back-to-back at full throughput
    for (int i = 0; i < NV; i++) begin
      tick();
      put(i, 32'h0000_2000 + 32'(i * 4));
    end
    tick();
    idle();
    drain("drain_directed");

    // Stall: two beats held, third waits until release
    tick();
    bus.out_ready = 1'b0;
    put(1, 32'h0000_3000);
    @(negedge clk);
    check("stall_acc1_ready", 32'(bus.in_ready), 32'd1);
    tick();
    put(2, 32'h0000_3004);
    @(negedge clk);
    check("stall_acc2_ready", 32'(bus.in_ready), 32'd1);
    tick();
    put(3, 32'h0000_3008);
    @(negedge clk);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_out_pc", bus.out_pc, 32'h0000_3000);
    tick();
    @(negedge clk);
    check("full_hold_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    @(negedge clk);
    check("release_pc2", bus.out_pc, 32'h0000_3004);
    check("release_ready2", 32'(bus.in_ready), 32'd1);
    tick();
    idle();
    @(negedge clk);
    check("release_pc3", bus.out_pc, 32'h0000_3008);
    check("release_valid3", 32'(bus.out_valid), 32'd1);
    drain("drain_stall");

    // Flush from FULL with a beat offered in the flush cycle
    tick();
    bus.out_ready = 1'b0;
    put(5, 32'h0000_5000);
    tick();
    put(6, 32'h0000_5004);
    tick();
    idle();
    @(negedge clk);
    check("pre_flush_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    flush = 1'b1;
    put(8, 32'hDEAD_0000);
    tick();
    flush = 1'b0;
    idle();
    @(negedge clk);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    put(7, 32'h0000_6000);
    tick();
    idle();
    drain("drain_after_flush");
    @(negedge clk);
    check("flush_no_leftover", 32'(bus.out_valid), 32'd0);

    // Flush in FULL with a simultaneous transfer: M consumed, S dropped
    bus.out_ready = 1'b0;
    tick();
    put(9, 32'h0000_7000);
    tick();
    put(10, 32'h0000_7004);
    tick();
    idle();
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_xfer_valid", 32'(bus.out_valid), 32'd0);

    // 100 beats with random in_valid and out_ready
    sent  = 0;
    guard = 0;
    while (sent < 100 && guard < 2000) begin
      tick();
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) != 0) put(sent % NV, 32'h0000_8000 + 32'(sent * 4));
      else idle();
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
      guard++;
    end
    if (sent < 100) begin
      n_vec++;
      n_bad++;
      $display("FAIL stream_accepts: got %0d accepts, expected 100", sent);
    end
    tick();
    idle();
    bus.out_ready = 1'b1;
    drain("drain_stream");

    // Reset while FULL, then a fresh beat
    tick();
    bus.out_ready = 1'b0;
    put(11, 32'h0000_9000);
    tick();
    put(12, 32'h0000_9004);
    tick();
    idle();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_full_valid", 32'(bus.out_valid), 32'd0);
    check("rst_full_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_full_imm", bus.out_imm, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    put(2, 32'h0000_A000);
    @(negedge clk);
    check("fresh_valid_n", 32'(bus.out_valid), 32'd0);
    tick();
    idle();
    @(negedge clk);
    check("fresh_valid_n1", 32'(bus.out_valid), 32'd1);
    check("fresh_imm", bus.out_imm, 32'h12345000);
    drain("drain_fresh");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
